load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have clk, input, 1, pipeline clock; all state updates on rising edge.
REQ-002 SHALL have rst, input, 1, reset, synchronous, active-high.
REQ-003 SHALL have in_valid, input, 1, EX/MEM stage holds a valid instruction.
REQ-004 SHALL have in_load / in_store, input, 1 each, access type; never both high.
REQ-005 SHALL have in_func3, input, 3, access size/sign per RV64 load/store encoding.
REQ-006 SHALL have in_addr, input, 64, effective address, or the ALU result for non-memory ops.
REQ-007 SHALL have in_wdata, input, 64, store data (rs2).
REQ-008 SHALL have in_rd, input, 5, destination register.
REQ-009 SHALL have mem_req, mem_we, output, 1 each; mem_addr, output, 64; mem_wdata, output, 64; mem_wstrb, output, 8.
REQ-010 SHALL have mem_ready, input, 1, access complete; mem_rdata, input, 64, valid when mem_ready=1.
REQ-011 SHALL have stall, output, 1, freezes all upstream pipeline registers.
REQ-012 SHALL have wb_valid, output, 1; wb_rd, output, 5; wb_data, output, 64 (MEM/WB payload).
REQ-013 SHALL have misalign_err, output, 1, one-cycle pulse (present only with the macro).

Function
REQ-014 SHALL implement FSM with states IDLE, BUSY, DONE.
REQ-015 IDLE, in_valid and neither in_load nor in_store: next cycle wb_valid=1, wb_data=in_addr, wb_rd=in_rd; state stays IDLE; no stall.
REQ-016 IDLE, in_valid and in_load or in_store: latch operands, go to BUSY; stall=1 combinationally in that same cycle.
REQ-017 BUSY: mem_req=1, with mem_addr={addr[63:3],3'b000}, mem_we, mem_wdata and mem_wstrb held stable until mem_ready is sampled high; stall=1.
REQ-018 BUSY with mem_ready=1: capture the aligned load result and go to DONE; stall stays 1 in that cycle.
REQ-019 DONE: stall=0, for exactly one cycle; a load drives wb_valid=1 with its data; a store drives wb_valid=0; next state IDLE.
REQ-020 Minimum load latency: accept at cycle 0, mem_req at cycle 1, mem_ready at cycle 1, wb_valid at cycle 2.
REQ-021 Loads: rdata shifted right by addr[2:0]*8, then extended per func3:
- 000 LB sign, 100 LBU zero
- 001 LH sign, 101 LHU zero
- 010 LW sign, 110 LWU zero
- 011 LD
REQ-022 Stores: data replicated into the byte lane selected by addr[2:0]; wstrb=0x01/0x03/0x0F/0xFF for SB/SH/SW/SD, shifted left by addr[2:0].
REQ-023 in_valid while BUSY or DONE SHALL be ignored; upstream holds the instruction under stall.
REQ-024 in_func3=111 on a memory op SHALL be treated as LD/SD.
REQ-025 Loads with in_rd=0 SHALL still access memory and assert wb_valid with wb_rd=0.

Reset
REQ-026 rst SHALL force state IDLE and, at the next edge, mem_req=0, mem_we=0, mem_wstrb=0, stall=0, wb_valid=0, wb_rd=0, wb_data=0, misalign_err=0.
REQ-027 rst during BUSY SHALL abandon the access; a late mem_ready after reset SHALL be ignored.

Configuration
REQ-028 With LSU_MISALIGN_TRAP_EN defined: a misaligned access (H with addr[0]!=0, W with addr[1:0]!=0, D with addr[2:0]!=0) SHALL issue no mem_req, pulse misalign_err one cycle later, keep wb_valid=0, and not stall.
REQ-029 Without LSU_MISALIGN_TRAP_EN: misalign_err port absent; address bits below the access size SHALL be forced to zero before lane selection.

Structure
REQ-030 Package lsu_pkg SHALL hold the func3 encodings, the FSM state enum, and the wstrb base constants.
REQ-031 Sub-module lsu_align (combinational) SHALL perform the store lane/strobe generation and the load shift/extend.

Verification
REQ-032 LB at addr 0x1003, rdata=0x0000_0000_80FF_0000 (byte 3=0x80), mem_ready at first req cycle -> wb_data=0xFFFF_FFFF_FFFF_FF80, wb_valid at cycle 2.
REQ-033 SH addr 0x2006, wdata 0xABCD -> mem_addr 0x2000, wstrb 0xC0, mem_wdata[63:48]=0xABCD, wb_valid stays 0.
REQ-034 LD with mem_ready delayed 5 cycles -> stall high 6 cycles, mem_req/addr stable throughout, single wb_valid.
REQ-035 ADD result 0x55, rd=7 -> wb_valid next cycle, wb_data 0x55, wb_rd 7, no mem_req.
REQ-036 rst asserted in BUSY, mem_ready one cycle later -> mem_req=0, no wb_valid, state IDLE.
REQ-037 With macro, LW addr 0x1002 -> no mem_req, misalign_err one-cycle pulse; without macro -> mem_addr 0x1000, wstrb-free read of bytes 0-3.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: func3 encodings, FSM states,
// byte-strobe base patterns and small address helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;
    localparam logic [2:0] F3_DX = 3'b111;

    localparam logic [7:0] STRB_B = 8'h01;
    localparam logic [7:0] STRB_H = 8'h03;
    localparam logic [7:0] STRB_W = 8'h0F;
    localparam logic [7:0] STRB_D = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    // Clear the byte-offset bits that lie below the natural size of the access.
    function automatic logic [2:0] align_offset(input logic [2:0] f3, input logic [2:0] off);
        case (f3)
            F3_B, F3_BU: return off;
            F3_H, F3_HU: return {off[2:1], 1'b0};
            F3_W, F3_WU: return {off[2], 2'b00};
            default:     return 3'b000;
        endcase
    endfunction

    // True when the byte offset is not a multiple of the access size.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [2:0] off);
        case (f3)
            F3_B, F3_BU: return 1'b0;
            F3_H, F3_HU: return off[0];
            F3_W, F3_WU: return |off[1:0];
            default:     return |off;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational byte-lane steering: store data/strobe placement and load
// result shift plus sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [2:0]  offset,
    input  logic [63:0] store_src,
    input  logic [63:0] load_src,
    output logic [63:0] store_data,
    output logic [7:0]  store_strb,
    output logic [63:0] load_data
);

    logic [5:0]  shamt;
    logic [63:0] shifted;
    logic        sign_ok;

    assign shamt = {offset, 3'b000};

    // Place the store data in its byte lane and build the matching strobe.
    always_comb begin
        store_data = store_src << shamt;
        case (func3[1:0])
            2'b00:   store_strb = STRB_B << offset;
            2'b01:   store_strb = STRB_H << offset;
            2'b10:   store_strb = STRB_W << offset;
            default: store_strb = STRB_D;
        endcase
    end

    // Bring the addressed bytes down to bit 0 and extend to 64 bits.
    always_comb begin
        shifted = load_src >> shamt;
        sign_ok = ~func3[2];
        case (func3[1:0])
            2'b00:   load_data = {{56{shifted[7]  & sign_ok}}, shifted[7:0]};
            2'b01:   load_data = {{48{shifted[15] & sign_ok}}, shifted[15:0]};
            2'b10:   load_data = {{32{shifted[31] & sign_ok}}, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit for the MEM stage. Memory ops go IDLE->BUSY->DONE and
// stall the pipeline until the DONE cycle; non-memory ops pass the ALU result
// straight to writeback. Optional macro LSU_MISALIGN_TRAP_EN turns misaligned
// accesses into a misalign_err pulse instead of silently aligning them.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_load,
    input  logic        in_store,
    input  logic [2:0]  in_func3,
    input  logic [63:0] in_addr,
    input  logic [63:0] in_wdata,
    input  logic [4:0]  in_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [63:0] mem_rdata,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_data
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic        misalign_err
`endif
);

    lsu_state_t  state, state_next;

    logic        op_load_q;
    logic        op_store_q;
    logic [2:0]  func3_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [4:0]  rd_q;

    logic        wb_valid_q;
    logic [4:0]  wb_rd_q;
    logic [63:0] wb_data_q;

    logic        accept_mem;
    logic        accept_alu;
    logic        trap;

    logic [63:0] store_data;
    logic [7:0]  store_strb;
    logic [63:0] load_data;

    lsu_align u_align (
        .func3      (func3_q),
        .offset     (addr_q[2:0]),
        .store_src  (wdata_q),
        .load_src   (mem_rdata),
        .store_data (store_data),
        .store_strb (store_strb),
        .load_data  (load_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode plus memory-port and stall outputs.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 64'd0;
        mem_wdata  = 64'd0;
        mem_wstrb  = 8'd0;
        accept_mem = 1'b0;
        accept_alu = 1'b0;
        trap       = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (in_load || in_store) begin
`ifdef LSU_MISALIGN_TRAP_EN
                        if (is_misaligned(in_func3, in_addr[2:0])) begin
                            trap = 1'b1;
                        end else begin
                            accept_mem = 1'b1;
                            stall      = 1'b1;
                            state_next = BUSY;
                        end
`else
                        accept_mem = 1'b1;
                        stall      = 1'b1;
                        state_next = BUSY;
`endif
                    end else begin
                        accept_alu = 1'b1;
                    end
                end
            end
            BUSY: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = op_store_q;
                mem_addr  = {addr_q[63:3], 3'b000};
                mem_wdata = store_data;
                mem_wstrb = op_store_q ? store_strb : 8'd0;
                if (mem_ready) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand latch and the registered MEM/WB payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_load_q  <= 1'b0;
            op_store_q <= 1'b0;
            func3_q    <= 3'd0;
            addr_q     <= 64'd0;
            wdata_q    <= 64'd0;
            rd_q       <= 5'd0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 64'd0;
        end else begin
            wb_valid_q <= 1'b0;
            if (accept_alu) begin
                wb_valid_q <= 1'b1;
                wb_rd_q    <= in_rd;
                wb_data_q  <= in_addr;
            end
            if (accept_mem) begin
                op_load_q  <= in_load;
                op_store_q <= in_store;
                func3_q    <= in_func3;
                addr_q     <= {in_addr[63:3], align_offset(in_func3, in_addr[2:0])};
                wdata_q    <= in_wdata;
                rd_q       <= in_rd;
            end
            if (state == BUSY && mem_ready) begin
                wb_valid_q <= op_load_q;
                wb_rd_q    <= rd_q;
                if (op_load_q) wb_data_q <= load_data;
            end
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q;

    // One-cycle error pulse following a rejected misaligned access.
    always_ff @(posedge clk) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= trap;
    end

    assign misalign_err = misalign_q;
`endif

    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_load;
    logic        in_store;
    logic [2:0]  in_func3;
    logic [63:0] in_addr;
    logic [63:0] in_wdata;
    logic [4:0]  in_rd;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_ready;
    logic [63:0] mem_rdata;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    load_store_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_load   (in_load),
        .in_store  (in_store),
        .in_func3  (in_func3),
        .in_addr   (in_addr),
        .in_wdata  (in_wdata),
        .in_rd     (in_rd),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .stall     (stall),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data)
`ifdef LSU_MISALIGN_TRAP_EN
        ,
        .misalign_err (misalign_err)
`endif
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic ld, input logic st,
                                 input logic [2:0] f3, input logic [63:0] a,
                                 input logic [63:0] wd, input logic [4:0] rd);
        in_valid = v;
        in_load  = ld;
        in_store = st;
        in_func3 = f3;
        in_addr  = a;
        in_wdata = wd;
        in_rd    = rd;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Single-cycle-ready load followed by a writeback check.
    task automatic doLoad(input string tag, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] rdata, input logic [4:0] rd,
                          input logic [63:0] exp_addr, input logic [63:0] exp_data);
        applyStimulus(1'b1, 1'b1, 1'b0, f3, a, 64'd0, rd);
        mem_rdata = rdata;
        tick();
        checkOutput({tag, "_req"}, {63'd0, mem_req}, 64'd1);
        checkOutput({tag, "_addr"}, mem_addr, exp_addr);
        mem_ready = 1'b1;
        tick();
        checkOutput({tag, "_wbv"}, {63'd0, wb_valid}, 64'd1);
        checkOutput({tag, "_wbd"}, wb_data, exp_data);
        checkOutput({tag, "_wbrd"}, {59'd0, wb_rd}, {59'd0, rd});
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
        mem_ready = 1'b0;
        tick();
    endtask

    // Single-cycle-ready store with checks on the bus fields.
    task automatic doStore(input string tag, input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] wd, input logic [63:0] exp_addr,
                           input logic [7:0] exp_strb, input logic [63:0] exp_wdata_masked);
        logic [63:0] lane_mask;
        applyStimulus(1'b1, 1'b0, 1'b1, f3, a, wd, 5'd1);
        tick();
        for (int b = 0; b < 8; b++) lane_mask[b*8 +: 8] = {8{exp_strb[b]}};
        checkOutput({tag, "_we"}, {63'd0, mem_we}, 64'd1);
        checkOutput({tag, "_addr"}, mem_addr, exp_addr);
        checkOutput({tag, "_strb"}, {56'd0, mem_wstrb}, {56'd0, exp_strb});
        checkOutput({tag, "_wdata"}, mem_wdata & lane_mask, exp_wdata_masked);
        mem_ready = 1'b1;
        tick();
        checkOutput({tag, "_wbv"}, {63'd0, wb_valid}, 64'd0);
        checkOutput({tag, "_stall"}, {63'd0, stall}, 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
        mem_ready = 1'b0;
        tick();
    endtask

    // Directed sequence.
    initial begin
        int stall_cnt;
        int wb_cnt;
        logic hold_ok;

        rst       = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = 64'd0;
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
        tick();
        tick();

        checkOutput("rst_req",   {63'd0, mem_req},  64'd0);
        checkOutput("rst_we",    {63'd0, mem_we},   64'd0);
        checkOutput("rst_strb",  {56'd0, mem_wstrb}, 64'd0);
        checkOutput("rst_stall", {63'd0, stall},    64'd0);
        checkOutput("rst_wbv",   {63'd0, wb_valid}, 64'd0);
        checkOutput("rst_wbrd",  {59'd0, wb_rd},    64'd0);
        checkOutput("rst_wbd",   wb_data,           64'd0);
        rst = 1'b0;

        $display("[TB] ALU passthrough");
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 64'h55, 64'd0, 5'd7);
        #1;
        checkOutput("alu_stall", {63'd0, stall},   64'd0);
        checkOutput("alu_req",   {63'd0, mem_req}, 64'd0);
        tick();
        checkOutput("alu_wbv",  {63'd0, wb_valid}, 64'd1);
        checkOutput("alu_wbd",  wb_data,           64'h55);
        checkOutput("alu_wbrd", {59'd0, wb_rd},    64'd7);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
        tick();
        checkOutput("alu_wbv_drop", {63'd0, wb_valid}, 64'd0);

        $display("[TB] LB minimum latency");
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b000, 64'h1003, 64'd0, 5'd3);
        #1;
        checkOutput("lb_c0_stall", {63'd0, stall},   64'd1);
        checkOutput("lb_c0_req",   {63'd0, mem_req}, 64'd0);
        tick();
        checkOutput("lb_c1_req",   {63'd0, mem_req}, 64'd1);
        checkOutput("lb_c1_addr",  mem_addr,         64'h1000);
        checkOutput("lb_c1_we",    {63'd0, mem_we},  64'd0);
        mem_rdata = 64'h0000_0000_80FF_0000;
        mem_ready = 1'b1;
        #1;
        checkOutput("lb_c1_stall", {63'd0, stall}, 64'd1);
        tick();
        checkOutput("lb_c2_wbv",   {63'd0, wb_valid}, 64'd1);
        checkOutput("lb_c2_wbd",   wb_data,           64'hFFFF_FFFF_FFFF_FF80);
        checkOutput("lb_c2_wbrd",  {59'd0, wb_rd},    64'd3);
        checkOutput("lb_c2_stall", {63'd0, stall},    64'd0);
        checkOutput("lb_c2_req",   {63'd0, mem_req},  64'd0);
        mem_ready = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
        tick();
        checkOutput("lb_c3_wbv", {63'd0, wb_valid}, 64'd0);

        $display("[TB] stores");
        doStore("sh", 3'b001, 64'h2006, 64'h0000_0000_0000_ABCD, 64'h2000, 8'hC0,
                64'hABCD_0000_0000_0000);
        doStore("sb", 3'b000, 64'h2105, 64'h1111_2222_3333_445A, 64'h2100, 8'h20,
                64'h0000_5A00_0000_0000);
        doStore("sw", 3'b010, 64'h2204, 64'h9999_8888_7654_3210, 64'h2200, 8'hF0,
                64'h7654_3210_0000_0000);
        doStore("sd111", 3'b111, 64'h6000, 64'hDEAD_BEEF_CAFE_F00D, 64'h6000, 8'hFF,
                64'hDEAD_BEEF_CAFE_F00D);

        $display("[TB] load extension variants");
        doLoad("lh",  3'b001, 64'h4002, 64'h0000_0000_8001_0000, 5'd4, 64'h4000,
               64'hFFFF_FFFF_FFFF_8001);
        doLoad("lhu", 3'b101, 64'h4002, 64'h0000_0000_8001_0000, 5'd5, 64'h4000,
               64'h0000_0000_0000_8001);
        doLoad("lw",  3'b010, 64'h5004, 64'h8765_4321_0000_0000, 5'd6, 64'h5000,
               64'hFFFF_FFFF_8765_4321);
        doLoad("lwu", 3'b110, 64'h5004, 64'h8765_4321_0000_0000, 5'd8, 64'h5000,
               64'h0000_0000_8765_4321);
        doLoad("lbu", 3'b100, 64'h5107, 64'hF000_0000_0000_0000, 5'd10, 64'h5100,
               64'h0000_0000_0000_00F0);
        doLoad("ld_rd0", 3'b011, 64'h5200, 64'h0123_4567_89AB_CDEF, 5'd0, 64'h5200,
               64'h0123_4567_89AB_CDEF);

        $display("[TB] LD with delayed ready");
        stall_cnt = 0;
        wb_cnt    = 0;
        hold_ok   = 1'b1;
        mem_rdata = 64'h1122_3344_5566_7788;
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b011, 64'h3008, 64'd0, 5'd9);
        #1;
        if (stall) stall_cnt++;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 5) mem_ready = 1'b1;
            #1;
            if (stall) stall_cnt++;
            if (!(mem_req === 1'b1 && mem_addr === 64'h3008 && mem_we === 1'b0)) hold_ok = 1'b0;
            if (wb_valid) wb_cnt++;
        end
        checkOutput("ld_stall_cycles", 64'(stall_cnt), 64'd6);
        checkOutput("ld_req_hold", {63'd0, hold_ok}, 64'd1);
        tick();
        mem_ready = 1'b0;
        checkOutput("ld_wbd",   wb_data,        64'h1122_3344_5566_7788);
        checkOutput("ld_wbrd",  {59'd0, wb_rd}, 64'd9);
        checkOutput("ld_stall", {63'd0, stall}, 64'd0);
        if (wb_valid) wb_cnt++;
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            if (wb_valid) wb_cnt++;
        end
        checkOutput("ld_wb_count", 64'(wb_cnt), 64'd1);

        $display("[TB] reset during BUSY");
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b011, 64'h7000, 64'd0, 5'd12);
        tick();
        checkOutput("rb_busy_req", {63'd0, mem_req}, 64'd1);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
        tick();
        checkOutput("rb_req",   {63'd0, mem_req},  64'd0);
        checkOutput("rb_stall", {63'd0, stall},    64'd0);
        checkOutput("rb_wbv",   {63'd0, wb_valid}, 64'd0);
        rst       = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        checkOutput("rb_late_wbv", {63'd0, wb_valid}, 64'd0);
        checkOutput("rb_late_req", {63'd0, mem_req},  64'd0);
        mem_ready = 1'b0;
        tick();
        checkOutput("rb_idle_wbv", {63'd0, wb_valid}, 64'd0);

        $display("[TB] misaligned LW");
`ifdef LSU_MISALIGN_TRAP_EN
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 64'h1002, 64'd0, 5'd2);
        #1;
        checkOutput("mis_stall", {63'd0, stall},   64'd0);
        checkOutput("mis_req",   {63'd0, mem_req}, 64'd0);
        tick();
        checkOutput("mis_err",     {63'd0, misalign_err}, 64'd1);
        checkOutput("mis_req2",    {63'd0, mem_req},      64'd0);
        checkOutput("mis_wbv",     {63'd0, wb_valid},     64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
        tick();
        checkOutput("mis_err_end", {63'd0, misalign_err}, 64'd0);
`else
        doLoad("mis_lw", 3'b010, 64'h1002, 64'hAAAA_BBBB_1234_5678, 5'd2, 64'h1000,
               64'h0000_0000_1234_5678);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
